ibex_l2_rf_ctrl: RTL

Parametrised successor to the flop-based L2 register file, used as the core-side scratch storage behind the load/store path. It has a req/gnt/rvalid handshake, a registered (1-cycle) read, byte-enabled writes, out-of-range detection and a hardware bulk-clear sequencer. The storage array is flip-flop based and suitable for FPGA synthesis and Verilator simulation.

---
 rtl/ibex_l2_rf_pkg.sv | 8 +
 rtl/ibex_l2_rf_if.sv | 21 ++
 rtl/ibex_l2_rf_clear_seq.sv | 35 +++
 rtl/ibex_l2_rf_ctrl.sv | 74 +++++++
 4 files changed

// File: rtl/ibex_l2_rf_pkg.sv
// ibex_l2_rf_pkg: shared FSM state enum, byte width and byte-parity helper for the L2 register file
package ibex_l2_rf_pkg;
  typedef enum logic {L2RF_IDLE, L2RF_CLEAR} l2_rf_state_e;
  localparam int L2RF_BYTE_W = 8;
  function automatic logic l2rf_byte_par(input logic [L2RF_BYTE_W-1:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/ibex_l2_rf_if.sv
// ibex_l2_rf_if: L2 register file bus; master drives req/we/addr/be/wdata/clear, slave returns gnt/rvalid/rdata/err/busy
interface ibex_l2_rf_if
  import ibex_l2_rf_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
);
  logic                             req;
  logic                             we;
  logic [AddrWidth-1:0]             addr;
  logic [DataWidth/L2RF_BYTE_W-1:0] be;
  logic [DataWidth-1:0]             wdata;
  logic                             clear;
  logic                             gnt;
  logic                             rvalid;
  logic [DataWidth-1:0]             rdata;
  logic                             err;
  logic                             busy;
  modport master (output req, we, addr, be, wdata, clear, input gnt, rvalid, rdata, err, busy);
  modport slave  (input req, we, addr, be, wdata, clear, output gnt, rvalid, rdata, err, busy);
endinterface

// File: rtl/ibex_l2_rf_clear_seq.sv
// ibex_l2_rf_clear_seq: bulk-clear FSM and word counter; in clk, rst, start; out clr_we, clr_addr, busy (registered state==CLEAR)
module ibex_l2_rf_clear_seq
  import ibex_l2_rf_pkg::*;
#(
  parameter int NumWords  = 24,
  parameter int AddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 clr_we,
  output logic [AddrWidth-1:0] clr_addr,
  output logic                 busy
);
  l2_rf_state_e         state, state_nxt;
  logic [AddrWidth-1:0] cnt;
  logic                 last;
  assign last     = cnt == AddrWidth'(NumWords - 1);
  assign busy     = state == L2RF_CLEAR;
  assign clr_we   = busy;
  assign clr_addr = cnt;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == L2RF_IDLE) ? (start ? L2RF_CLEAR : L2RF_IDLE) : (last ? L2RF_IDLE : L2RF_CLEAR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= L2RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= busy ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/ibex_l2_rf_ctrl.sv
// ibex_l2_rf_ctrl: flop-based L2 register file; ports clk_i, rst_i, bus (slave modport); IBEX_L2_RF_PARITY_EN adds per-byte even parity
module ibex_l2_rf_ctrl
  import ibex_l2_rf_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int NumWords  = 24,
  parameter int ZeroWord0 = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  ibex_l2_rf_if.slave  bus
);
  localparam int AddrWidth = $clog2(NumWords);
  localparam int NB        = DataWidth / L2RF_BYTE_W;
  logic [DataWidth-1:0] mem [NumWords];
  logic                 clr_we, busy, wr, rd, in_range, zero0, perr;
  logic [AddrWidth-1:0] clr_addr;
  ibex_l2_rf_clear_seq #(.NumWords(NumWords), .AddrWidth(AddrWidth)) u_clear_seq (
    .clk      (clk_i),
    .rst      (rst_i),
    .start    (bus.clear),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );
  assign bus.busy = busy;
  assign bus.gnt  = bus.req & ~busy & ~bus.clear;
  assign wr       = bus.gnt & bus.we;
  assign rd       = bus.gnt & ~bus.we;
  assign in_range = 32'(bus.addr) < NumWords;
  assign zero0    = (ZeroWord0 != 0) && (bus.addr == '0);
  // clr_we and wr are exclusive: grants are blocked while the sequencer runs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWords; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr && in_range && !zero0) begin
      for (int b = 0; b < NB; b++)
        if (bus.be[b]) mem[bus.addr][b*L2RF_BYTE_W +: L2RF_BYTE_W] <= bus.wdata[b*L2RF_BYTE_W +: L2RF_BYTE_W];
    end
  end
`ifdef IBEX_L2_RF_PARITY_EN
  logic [NB-1:0] par [NumWords];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWords; i++) par[i] <= '0;
    end else if (clr_we) begin
      par[clr_addr] <= '0;
    end else if (wr && in_range && !zero0) begin
      for (int b = 0; b < NB; b++)
        if (bus.be[b]) par[bus.addr][b] <= l2rf_byte_par(bus.wdata[b*L2RF_BYTE_W +: L2RF_BYTE_W]);
    end
  end
  always_comb begin
    perr = 1'b0;
    for (int b = 0; b < NB; b++)
      perr = perr | (l2rf_byte_par(mem[bus.addr][b*L2RF_BYTE_W +: L2RF_BYTE_W]) != par[bus.addr][b]);
  end
`else
  assign perr = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= rd;
      bus.err    <= rd & (~in_range | (~zero0 & perr));
      if (rd) bus.rdata <= (in_range && !zero0) ? mem[bus.addr] : '0;
    end
  end
endmodule
